kypd_scanner: RTL

- Scans a 4x4 matrix keypad and produces a debounced 4-bit key code plus a valid flag.
- Its outputs feed the keypad decoder's key_value_i directly, which turns the code into a tone divide factor.
- Drives one column low at a time and samples the active-low row lines.
- Resolves multi-key presses by fixed priority and commits a key only after it has been stable for several full scans.

---
 rtl/kypd_scanner.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/kypd_scanner.sv
// 4x4 matrix keypad scanner: one active-low column at a time, priority-resolved and debounced key code.
// Optional build macro KYPD_HOLD_LAST_EN: keep the last committed code on key_value_o after a release.
module kypd_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_value_o,
  output logic       key_valid_o,
  output logic       key_press_o,
  output logic       key_release_o
);

  localparam int             CW         = $clog2(SCAN_DIV);
  localparam int             SW         = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]  DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [SW-1:0]  STABLE_MAX = SW'(DEBOUNCE_SCANS);
  localparam logic [SW-1:0]  STABLE_ONE = SW'(1);
  // Candidates are {key_present, code}; all-zero means no key.
  localparam logic [4:0]     CAND_NONE  = 5'b0_0000;

  function automatic logic [3:0] key_code(input logic [1:0] col, input logic [1:0] row);
    case ({col, row})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h4;
      4'h2: key_code = 4'h7;
      4'h3: key_code = 4'h0;
      4'h4: key_code = 4'h2;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h8;
      4'h7: key_code = 4'hF;
      4'h8: key_code = 4'h3;
      4'h9: key_code = 4'h6;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hE;
      4'hC: key_code = 4'hA;
      4'hD: key_code = 4'hB;
      4'hE: key_code = 4'hC;
      4'hF: key_code = 4'hD;
      default: key_code = 4'h0;
    endcase
  endfunction

  // Returns {hit, row} for the lowest pressed row.
  function automatic logic [2:0] first_row(input logic [3:0] pressed);
    if (pressed[0])      first_row = 3'b1_00;
    else if (pressed[1]) first_row = 3'b1_01;
    else if (pressed[2]) first_row = 3'b1_10;
    else if (pressed[3]) first_row = 3'b1_11;
    else                 first_row = 3'b0_00;
  endfunction

  logic [3:0]    row_meta_r, row_sync_r;
  logic [CW-1:0] dwell_cnt_r;
  logic [1:0]    col_idx_r;
  logic          scan_hit_r;
  logic [3:0]    scan_code_r;
  logic [4:0]    prev_cand_r, committed_r;
  logic [SW-1:0] stable_cnt_r;

  logic          sample_s, scan_end_s, found_s, commit_s;
  logic [2:0]    row_pick_s;
  logic [3:0]    found_code_s;
  logic [1:0]    col_next_s;
  logic [4:0]    cand_s;
  logic [SW-1:0] stable_next_s;

  assign sample_s   = (dwell_cnt_r == DWELL_LAST);
  assign scan_end_s = sample_s && (col_idx_r == 2'd3);
  assign col_next_s = col_idx_r + 2'd1;
  assign row_pick_s = first_row(~row_sync_r);

  // Running scan result including the column currently being sampled; column 0 starts a fresh scan.
  always_comb begin
    found_s       = 1'b0;
    found_code_s  = 4'h0;
    cand_s        = CAND_NONE;
    stable_next_s = STABLE_ONE;
    if ((col_idx_r != 2'd0) && scan_hit_r) begin
      found_s      = 1'b1;
      found_code_s = scan_code_r;
    end else if (row_pick_s[2]) begin
      found_s      = 1'b1;
      found_code_s = key_code(col_idx_r, row_pick_s[1:0]);
    end else begin
      found_s      = 1'b0;
      found_code_s = 4'h0;
    end
    if (found_s) cand_s = {1'b1, found_code_s};
    else         cand_s = CAND_NONE;
    if (cand_s != prev_cand_r)           stable_next_s = STABLE_ONE;
    else if (stable_cnt_r == STABLE_MAX) stable_next_s = STABLE_MAX;
    else                                 stable_next_s = stable_cnt_r + STABLE_ONE;
  end

  assign commit_s = scan_end_s && (stable_next_s == STABLE_MAX) && (cand_s != committed_r);

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row_i;
      row_sync_r <= row_meta_r;
    end
  end

  // Column dwell timer, column drive and per-scan first-hit capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dwell_cnt_r <= '0;
      col_idx_r   <= 2'd0;
      col_o       <= 4'b1110;
      scan_hit_r  <= 1'b0;
      scan_code_r <= 4'h0;
    end else if (sample_s) begin
      dwell_cnt_r <= '0;
      col_idx_r   <= col_next_s;
      col_o       <= 4'b1111 ^ (4'b0001 << col_next_s);
      scan_hit_r  <= found_s;
      scan_code_r <= found_code_s;
    end else begin
      dwell_cnt_r <= dwell_cnt_r + CNT_ONE;
    end
  end

  // Scan-to-scan stability tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_cand_r  <= CAND_NONE;
      stable_cnt_r <= '0;
    end else if (scan_end_s) begin
      prev_cand_r  <= cand_s;
      stable_cnt_r <= stable_next_s;
    end
  end

  // Commit of a debounced press, release or direct key change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      committed_r   <= CAND_NONE;
      key_value_o   <= 4'h0;
      key_valid_o   <= 1'b0;
      key_press_o   <= 1'b0;
      key_release_o <= 1'b0;
    end else begin
      key_press_o   <= 1'b0;
      key_release_o <= 1'b0;
      if (commit_s) begin
        committed_r <= cand_s;
        if (cand_s[4]) begin
          key_value_o   <= cand_s[3:0];
          key_valid_o   <= 1'b1;
          key_press_o   <= 1'b1;
          key_release_o <= committed_r[4];
        end else begin
          key_valid_o   <= 1'b0;
          key_release_o <= 1'b1;
`ifdef KYPD_HOLD_LAST_EN
          key_value_o   <= key_value_o;
`else
          key_value_o   <= 4'h0;
`endif
        end
      end
    end
  end

endmodule
